reg_rename_file: RTL and testbench
==================================

// Module: reg_rename_file
// PURPOSE
//  Architectural register file with rename tags. Sits beside the reorder buffer (ROB).
//  Serves decoder operand lookups: value, or ROB tag of the pending producer. Resolves tags via ROB query ports.
//  Renames rd at dispatch. Retires ROB commits into architectural state.
// PARAMETERS
//  REG_WIDTH   5    register index width (32 regs, x0 hardwired 0)
//  ROB_WIDTH   3    ROB tag width (shared `ROB_WIDTH in params.v)
//  XLEN        32   data width
// PORTS
//  clk_in          in   1          clock
//  rst_in          in   1          asynchronous, active-high reset
//  rdy_in          in   1          global enable; state holds when low
//  flush           in   1          mispredict flush from ROB (flush_out)
//  dec_rs1/dec_rs2 in   REG_WIDTH  source register indices
//  dec_rename_en   in   1          dispatch this cycle; rename dec_rd
//  dec_rd          in   REG_WIDTH  destination register
//  dec_rob_id      in   ROB_WIDTH  tag allocated by ROB (dec_empty_id)
//  dec_val_j/k     out  XLEN       operand value (valid when !dec_busy_*)
//  dec_busy_j/k    out  1          operand still pending
//  dec_dep_j/k     out  ROB_WIDTH  producer tag (valid when dec_busy_*)
//  rob_query_j/k   out  ROB_WIDTH  tag lookup to ROB (reg_rob_id_j/k)
//  rob_ready_j/k   in   1          ROB reports tag result available
//  rob_data_j/k    in   XLEN       ROB result for queried tag
//  commit_reg_id   in   REG_WIDTH  commit dest; 0 = no write
//  commit_data     in   XLEN       commit value
//  commit_rob_id   in   ROB_WIDTH  tag of committing entry
// BEHAVIOUR
//  State: regs[32] (XLEN), busy[32], tag[32] (ROB_WIDTH).
//  Reset (async): all regs=0, busy=0, tag=0. No registered outputs; all outputs combinational from state.
//  Lookup (combinational, 0 cycles), per source s in {j,k} with index rs:
//   rs==0 -> val=0, busy=0, dep=0.
//   !busy[rs] -> val=regs[rs], busy=0.
//   busy[rs] && rob_ready -> val=rob_data, busy=0.
//   busy[rs] && !rob_ready -> busy=1, dep=tag[rs], val=0.
//   rob_query = tag[rs] always (don't-care when not busy).
//   Lookup uses pre-edge state: a dispatch with rs==rd sees the OLD mapping, not its own tag.
//  Update at posedge clk_in when rdy_in=1:
//   flush=1 -> busy[*]<=0; commit and rename ignored that cycle (ROB drops its head on flush); regs keep values.
//   Else commit (commit_reg_id!=0): regs[id]<=commit_data;
//    busy[id]<=0 only if tag[id]==commit_rob_id (newer producer keeps busy).
//   Else rename (dec_rename_en && dec_rd!=0): busy[rd]<=1, tag[rd]<=dec_rob_id.
//   Commit and rename of the same reg in one cycle: data written, rename wins (busy=1, new tag).
//  rdy_in=0: no state change; lookups still combinational.
//  x0: never written, never busy, regardless of commit/rename inputs.
// CONFIGURATION
//  REG_PERF_CNT_EN defined: adds outputs perf_commit_cnt[31:0] (commits with id!=0) and
//   perf_stall_cnt[31:0] (cycles with dec_rename_en and any dec_busy_*).
//   Both wrap at 2^32, reset to 0, are not cleared by flush, and count only when rdy_in=1.
//  REG_PERF_CNT_EN undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  params.v: REG_WIDTH, ROB_WIDTH, REG_COUNT=32 constants; no new typedefs.
//  One sub-module, reg_src_lookup: single-source lookup mux; instantiated twice (j, k).
// TESTING
//  Reset mid-run with busy regs -> every lookup returns busy=0, val=0 immediately (async).
//  Rename x5->tag 2; lookup x5, rob_ready=0 -> busy=1, dep=2. rob_ready=1, rob_data=0xAB -> val=0xAB, busy=0.
//  Rename x5->tag 1, then x5->tag 3; commit x5 tag 1 data 7 -> regs[5]=7, busy stays 1, dep=3.
//  Same cycle: commit x6 tag 4 data 9, rename x6->tag 5 -> next cycle busy=1, dep=5; later commit tag 5 -> busy=0.
//  Commit x0 data 0xFFFF and rename x0 -> lookup x0 gives val=0, busy=0.
//  Flush with commit x7 tag 2 pending, busy x7/x8 -> busy all 0, regs[7] unchanged.
//   With rdy_in=0 the same stimulus changes nothing.

Source files
------------

// File: rtl/reg_rename_file_pkg.sv
// Shared sizing constants for the rename register file.
// Optional build macro: REG_PERF_CNT_EN (commit/stall performance counters).
package reg_rename_file_pkg;

    localparam int REG_WIDTH = 5;
    localparam int ROB_WIDTH = 3;
    localparam int XLEN      = 32;
    localparam int REG_COUNT = 1 << REG_WIDTH;
    localparam int NUM_SRC   = 2;

    // x0 is hardwired; only non-zero indices carry state.
    function automatic logic live_reg(input logic [REG_WIDTH-1:0] idx);
        return idx != '0;
    endfunction

endpackage

// File: rtl/reg_rename_file_if.sv
// Decoder / ROB / commit bundle between the pipeline and the rename register file.
interface reg_rename_file_if;
    import reg_rename_file_pkg::*;

    logic                 flush;
    logic [REG_WIDTH-1:0] dec_rs1;
    logic [REG_WIDTH-1:0] dec_rs2;
    logic                 dec_rename_en;
    logic [REG_WIDTH-1:0] dec_rd;
    logic [ROB_WIDTH-1:0] dec_rob_id;
    logic [XLEN-1:0]      dec_val_j;
    logic [XLEN-1:0]      dec_val_k;
    logic                 dec_busy_j;
    logic                 dec_busy_k;
    logic [ROB_WIDTH-1:0] dec_dep_j;
    logic [ROB_WIDTH-1:0] dec_dep_k;
    logic [ROB_WIDTH-1:0] rob_query_j;
    logic [ROB_WIDTH-1:0] rob_query_k;
    logic                 rob_ready_j;
    logic                 rob_ready_k;
    logic [XLEN-1:0]      rob_data_j;
    logic [XLEN-1:0]      rob_data_k;
    logic [REG_WIDTH-1:0] commit_reg_id;
    logic [XLEN-1:0]      commit_data;
    logic [ROB_WIDTH-1:0] commit_rob_id;

    modport master (
        output flush, dec_rs1, dec_rs2, dec_rename_en, dec_rd, dec_rob_id,
               rob_ready_j, rob_ready_k, rob_data_j, rob_data_k,
               commit_reg_id, commit_data, commit_rob_id,
        input  dec_val_j, dec_val_k, dec_busy_j, dec_busy_k,
               dec_dep_j, dec_dep_k, rob_query_j, rob_query_k
    );

    modport slave (
        input  flush, dec_rs1, dec_rs2, dec_rename_en, dec_rd, dec_rob_id,
               rob_ready_j, rob_ready_k, rob_data_j, rob_data_k,
               commit_reg_id, commit_data, commit_rob_id,
        output dec_val_j, dec_val_k, dec_busy_j, dec_busy_k,
               dec_dep_j, dec_dep_k, rob_query_j, rob_query_k
    );

endinterface

// File: rtl/reg_rename_file_src_lookup.sv
// Single-source operand lookup: architectural value, ROB-forwarded value, or pending tag.
module reg_src_lookup
    import reg_rename_file_pkg::*;
(
    input  logic [REG_WIDTH-1:0]                rs,
    input  logic [REG_COUNT-1:0][XLEN-1:0]      regs,
    input  logic [REG_COUNT-1:0]                busy,
    input  logic [REG_COUNT-1:0][ROB_WIDTH-1:0] tags,
    input  logic                                rob_ready,
    input  logic [XLEN-1:0]                     rob_data,
    output logic [XLEN-1:0]                     val,
    output logic                                src_busy,
    output logic [ROB_WIDTH-1:0]                dep,
    output logic [ROB_WIDTH-1:0]                query
);

    // The ROB is always asked about the mapped tag; it is ignored when not busy.
    assign query = tags[rs];

    always_comb begin
        val      = '0;
        src_busy = 1'b0;
        dep      = '0;
        if (!live_reg(rs)) begin
            val = '0;
        end else if (!busy[rs]) begin
            val = regs[rs];
            dep = tags[rs];
        end else if (rob_ready) begin
            val = rob_data;
            dep = tags[rs];
        end else begin
            src_busy = 1'b1;
            dep      = tags[rs];
        end
    end

endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file with ROB rename tags; two combinational operand lookups.
// Optional build macro: REG_PERF_CNT_EN adds perf_commit_cnt / perf_stall_cnt outputs.
module reg_rename_file
    import reg_rename_file_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    reg_rename_file_if.slave  bus
`ifdef REG_PERF_CNT_EN
    ,
    output logic [31:0]       perf_commit_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    logic [REG_COUNT-1:0][XLEN-1:0]      regs;
    logic [REG_COUNT-1:0]                busy;
    logic [REG_COUNT-1:0][ROB_WIDTH-1:0] tags;

    logic [NUM_SRC-1:0][REG_WIDTH-1:0] src_rs;
    logic [NUM_SRC-1:0]                src_ready;
    logic [NUM_SRC-1:0][XLEN-1:0]      src_rdata;
    logic [NUM_SRC-1:0][XLEN-1:0]      src_val;
    logic [NUM_SRC-1:0]                src_busy;
    logic [NUM_SRC-1:0][ROB_WIDTH-1:0] src_dep;
    logic [NUM_SRC-1:0][ROB_WIDTH-1:0] src_query;

    assign src_rs[0]    = bus.dec_rs1;
    assign src_rs[1]    = bus.dec_rs2;
    assign src_ready[0] = bus.rob_ready_j;
    assign src_ready[1] = bus.rob_ready_k;
    assign src_rdata[0] = bus.rob_data_j;
    assign src_rdata[1] = bus.rob_data_k;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        reg_src_lookup u_lookup (
            .rs        (src_rs[g]),
            .regs      (regs),
            .busy      (busy),
            .tags      (tags),
            .rob_ready (src_ready[g]),
            .rob_data  (src_rdata[g]),
            .val       (src_val[g]),
            .src_busy  (src_busy[g]),
            .dep       (src_dep[g]),
            .query     (src_query[g])
        );
    end

    assign bus.dec_val_j   = src_val[0];
    assign bus.dec_val_k   = src_val[1];
    assign bus.dec_busy_j  = src_busy[0];
    assign bus.dec_busy_k  = src_busy[1];
    assign bus.dec_dep_j   = src_dep[0];
    assign bus.dec_dep_k   = src_dep[1];
    assign bus.rob_query_j = src_query[0];
    assign bus.rob_query_k = src_query[1];

    logic do_commit;
    logic do_rename;

    assign do_commit = !bus.flush && live_reg(bus.commit_reg_id);
    assign do_rename = !bus.flush && bus.dec_rename_en && live_reg(bus.dec_rd);

    // Rename is scheduled after commit so it wins on a same-register collision.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            regs <= '0;
            busy <= '0;
            tags <= '0;
        end else if (rdy_in) begin
            if (bus.flush) begin
                busy <= '0;
            end
            if (do_commit) begin
                regs[bus.commit_reg_id] <= bus.commit_data;
                if (tags[bus.commit_reg_id] == bus.commit_rob_id)
                    busy[bus.commit_reg_id] <= 1'b0;
            end
            if (do_rename) begin
                busy[bus.dec_rd] <= 1'b1;
                tags[bus.dec_rd] <= bus.dec_rob_id;
            end
        end
    end

`ifdef REG_PERF_CNT_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            perf_commit_cnt <= '0;
            perf_stall_cnt  <= '0;
        end else if (rdy_in) begin
            if (do_commit)
                perf_commit_cnt <= perf_commit_cnt + 32'd1;
            if (bus.dec_rename_en && (|src_busy))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_reg_rename_file.sv
// Scoreboard bench for reg_rename_file: directed rename/commit/flush cases plus a random phase.
module tb_reg_rename_file;
    import reg_rename_file_pkg::*;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;

    reg_rename_file_if bus ();

`ifdef REG_PERF_CNT_EN
    logic [31:0] perf_commit_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    reg_rename_file dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
`ifdef REG_PERF_CNT_EN
        ,
        .perf_commit_cnt (perf_commit_cnt),
        .perf_stall_cnt  (perf_stall_cnt)
`endif
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // reference state
    logic [31:0] m_regs [32];
    logic        m_busy [32];
    logic [2:0]  m_tag  [32];
    logic [31:0] m_pc = 0;
    logic [31:0] m_ps = 0;

    typedef struct {
        string       tag;
        int          lane;
        int          fld;
        logic [31:0] exp;
    } sb_t;
    sb_t sbq[$];

    function automatic void m_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
            m_tag[i]  = '0;
        end
    endfunction

    function automatic logic [31:0] obs_of(input int lane, input int fld);
        case (fld)
            0:       return lane == 0 ? bus.dec_val_j : bus.dec_val_k;
            1:       return lane == 0 ? 32'(bus.dec_busy_j) : 32'(bus.dec_busy_k);
            2:       return lane == 0 ? 32'(bus.dec_dep_j) : 32'(bus.dec_dep_k);
            default: return lane == 0 ? 32'(bus.rob_query_j) : 32'(bus.rob_query_k);
        endcase
    endfunction

    function automatic logic m_src_busy(input int rs, input logic rr);
        return rs != 0 && m_busy[rs] && !rr;
    endfunction

    function automatic void push(input string nm, input int lane, input int fld, input logic [31:0] e);
        sb_t s;
        s.tag = nm; s.lane = lane; s.fld = fld; s.exp = e;
        sbq.push_back(s);
    endfunction

    function automatic void push_exp(input string nm, input int lane, input int rs,
                                     input logic rr, input logic [31:0] rdat);
        push({nm, "_query"}, lane, 3, 32'(m_tag[rs]));
        if (rs == 0) begin
            push({nm, "_val"}, lane, 0, 0);
            push({nm, "_busy"}, lane, 1, 0);
            push({nm, "_dep"}, lane, 2, 0);
        end else if (!m_busy[rs]) begin
            push({nm, "_val"}, lane, 0, m_regs[rs]);
            push({nm, "_busy"}, lane, 1, 0);
        end else if (rr) begin
            push({nm, "_val"}, lane, 0, rdat);
            push({nm, "_busy"}, lane, 1, 0);
        end else begin
            push({nm, "_val"}, lane, 0, 0);
            push({nm, "_busy"}, lane, 1, 1);
            push({nm, "_dep"}, lane, 2, 32'(m_tag[rs]));
        end
    endfunction

    task automatic drain();
        while (sbq.size() > 0) begin
            sb_t s;
            s = sbq.pop_front();
            chk(s.tag, obs_of(s.lane, s.fld), s.exp);
        end
    endtask

    task automatic look(input string nm, input int rs1, input int rs2,
                        input logic rj, input logic [31:0] dj,
                        input logic rk, input logic [31:0] dk);
        bus.dec_rs1     = 5'(rs1);
        bus.dec_rs2     = 5'(rs2);
        bus.rob_ready_j = rj;
        bus.rob_data_j  = dj;
        bus.rob_ready_k = rk;
        bus.rob_data_k  = dk;
        #1;
        push_exp({nm, "_j"}, 0, rs1, rj, dj);
        push_exp({nm, "_k"}, 1, rs2, rk, dk);
        drain();
    endtask

    task automatic idle();
        bus.flush         = 1'b0;
        bus.dec_rename_en = 1'b0;
        bus.dec_rd        = '0;
        bus.dec_rob_id    = '0;
        bus.commit_reg_id = '0;
        bus.commit_data   = '0;
        bus.commit_rob_id = '0;
    endtask

    // Advance one clock, updating the reference from the inputs held across the edge.
    task automatic cyc();
        int cid, rd;
        cid = int'(bus.commit_reg_id);
        rd  = int'(bus.dec_rd);
        if (rdy_in) begin
            if (bus.dec_rename_en && (m_src_busy(int'(bus.dec_rs1), bus.rob_ready_j) ||
                                      m_src_busy(int'(bus.dec_rs2), bus.rob_ready_k)))
                m_ps++;
            if (bus.flush) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end else begin
                if (cid != 0) begin
                    m_pc++;
                    m_regs[cid] = bus.commit_data;
                    if (m_tag[cid] == bus.commit_rob_id) m_busy[cid] = 1'b0;
                end
                if (bus.dec_rename_en && rd != 0) begin
                    m_busy[rd] = 1'b1;
                    m_tag[rd]  = bus.dec_rob_id;
                end
            end
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic rename(input int rd, input int tag);
        idle();
        bus.dec_rename_en = 1'b1;
        bus.dec_rd        = 5'(rd);
        bus.dec_rob_id    = 3'(tag);
        cyc();
        idle();
    endtask

    task automatic commit(input int id, input int tag, input logic [31:0] data);
        idle();
        bus.commit_reg_id = 5'(id);
        bus.commit_rob_id = 3'(tag);
        bus.commit_data   = data;
        cyc();
        idle();
    endtask

    initial begin
        m_reset();
        rst_in = 1'b1;
        rdy_in = 1'b1;
        idle();
        bus.dec_rs1 = '0; bus.dec_rs2 = '0;
        bus.rob_ready_j = 1'b0; bus.rob_ready_k = 1'b0;
        bus.rob_data_j = '0; bus.rob_data_k = '0;
        #12 rst_in = 1'b0;
        @(posedge clk_in); #1;

        look("rst", 5, 31, 1'b0, 0, 1'b0, 0);

        // rename x5 -> tag 2, resolve through the ROB
        rename(5, 2);
        look("x5_pend", 5, 0, 1'b0, 0, 1'b0, 0);
        chk("x5_dep_const", 32'(bus.dec_dep_j), 2);
        chk("x5_query_const", 32'(bus.rob_query_j), 2);
        look("x5_fwd", 0, 5, 1'b0, 0, 1'b1, 32'hAB);
        chk("x5_fwd_const", bus.dec_val_k, 32'hAB);

        // dispatch reading its own rd still sees the previous mapping
        bus.dec_rename_en = 1'b1; bus.dec_rd = 5'd5; bus.dec_rob_id = 3'd6;
        look("self_dep", 5, 5, 1'b0, 0, 1'b0, 0);
        chk("self_dep_const", 32'(bus.dec_dep_j), 2);
        cyc();
        idle();
        look("self_after", 5, 0, 1'b0, 0, 1'b0, 0);

        // older commit must not clear a newer producer
        rename(5, 1);
        rename(5, 3);
        commit(5, 1, 32'd7);
        look("old_commit", 5, 5, 1'b0, 0, 1'b1, 32'h55);
        chk("old_commit_busy", 32'(bus.dec_busy_j), 1);
        chk("old_commit_dep", 32'(bus.dec_dep_j), 3);
        bus.flush = 1'b1; cyc(); idle();
        look("x5_flushed", 5, 0, 1'b0, 0, 1'b0, 0);
        chk("x5_regval", bus.dec_val_j, 7);

        // commit and rename of x6 in the same cycle: rename wins
        idle();
        bus.commit_reg_id = 5'd6; bus.commit_rob_id = 3'd4; bus.commit_data = 32'd9;
        bus.dec_rename_en = 1'b1; bus.dec_rd = 5'd6; bus.dec_rob_id = 3'd5;
        cyc(); idle();
        look("x6_same", 6, 6, 1'b0, 0, 1'b0, 0);
        chk("x6_same_dep", 32'(bus.dec_dep_k), 5);
        commit(6, 5, 32'h11);
        look("x6_done", 6, 0, 1'b0, 0, 1'b0, 0);
        chk("x6_done_val", bus.dec_val_j, 32'h11);

        // x0 stays zero and idle
        idle();
        bus.commit_reg_id = 5'd0; bus.commit_rob_id = 3'd0; bus.commit_data = 32'hFFFF;
        bus.dec_rename_en = 1'b1; bus.dec_rd = 5'd0; bus.dec_rob_id = 3'd3;
        cyc(); idle();
        look("x0", 0, 0, 1'b1, 32'h1234, 1'b0, 0);
        chk("x0_val", bus.dec_val_j, 0);

        // flush with a commit pending, first while stalled, then enabled
        rename(7, 1);
        commit(7, 1, 32'h70);
        rename(7, 2);
        rename(8, 4);
        bus.flush = 1'b1;
        bus.commit_reg_id = 5'd7; bus.commit_rob_id = 3'd2; bus.commit_data = 32'h99;
        bus.dec_rename_en = 1'b1; bus.dec_rd = 5'd9; bus.dec_rob_id = 3'd1;
        rdy_in = 1'b0;
        cyc();
        look("stall", 7, 8, 1'b0, 0, 1'b0, 0);
        chk("stall_dep7", 32'(bus.dec_dep_j), 2);
        chk("stall_busy8", 32'(bus.dec_busy_k), 1);
        look("stall_x9", 9, 0, 1'b0, 0, 1'b0, 0);
        rdy_in = 1'b1;
        cyc(); idle();
        look("flush", 7, 8, 1'b0, 0, 1'b0, 0);
        chk("flush_x7_val", bus.dec_val_j, 32'h70);
        look("flush_x9", 9, 0, 1'b0, 0, 1'b0, 0);

        // random traffic against the reference
        for (int n = 0; n < 300; n++) begin
            idle();
            rdy_in = ($urandom_range(9) != 0);
            bus.flush = ($urandom_range(19) == 0);
            bus.dec_rename_en = $urandom_range(1);
            bus.dec_rd = 5'($urandom_range(31));
            bus.dec_rob_id = 3'($urandom_range(7));
            bus.commit_reg_id = ($urandom_range(2) == 0) ? 5'd0 : 5'($urandom_range(31));
            bus.commit_data = $urandom;
            bus.commit_rob_id = $urandom_range(1) ? m_tag[bus.commit_reg_id] : 3'($urandom_range(7));
            look("rnd", $urandom_range(31), $urandom_range(31),
                 1'($urandom_range(1)), $urandom, 1'($urandom_range(1)), $urandom);
            cyc();
        end
        idle();
        rdy_in = 1'b1;

`ifdef REG_PERF_CNT_EN
        chk("perf_commit", perf_commit_cnt, m_pc);
        chk("perf_stall", perf_stall_cnt, m_ps);
`endif

        // asynchronous reset mid-run with busy registers
        rename(10, 3);
        rename(11, 6);
        rst_in = 1'b1;
        #1;
        m_reset();
        m_pc = 0; m_ps = 0;
        look("async_rst", 10, 11, 1'b0, 0, 1'b0, 0);
        chk("async_rst_busy", 32'(bus.dec_busy_j), 0);
        chk("async_rst_val", bus.dec_val_k, 0);
        #1 rst_in = 1'b0;
        @(posedge clk_in); #1;
`ifdef REG_PERF_CNT_EN
        chk("perf_rst", perf_commit_cnt, 0);
`endif
        look("post_rst", 5, 7, 1'b0, 0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
